// File: rtl/irq_pend_gen.sv
// irq_pend_gen: machine timer (mtime/mtimecmp), software-interrupt bits and external IRQ synchronizers.
// Latency: ack one cycle after an accepted req; mtip one cycle after the compare; eip SYNC_STAGES+1 edges.
// Backpressure: none; a req seen while ack is high is dropped, so a held req completes every 2 cycles.
//
// Ports:
//   clk_in, reset_in (async, active-low)
//   req/we/addr/wdata  -> single-beat bus request; ack/rdata/err one cycle later
//   ext_irq_async[2:0] -> [0]=user, [1]=supervisor, [2]=machine external IRQ (async level)
//   usip/ssip/msip     <- software pending bits (SWI register)
//   utip/stip/mtip     <- timer pending; only mtip is live
//   ueip/seip/meip     <- synchronized external pending bits
module irq_pend_gen #(
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int RSZ         = 32
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic           req,
  input  logic           we,
  input  logic [4:0]     addr,
  input  logic [RSZ-1:0] wdata,
  output logic           ack,
  output logic [RSZ-1:0] rdata,
  output logic           err,
  input  logic [2:0]     ext_irq_async,
  output logic           usip,
  output logic           ssip,
  output logic           msip,
  output logic           utip,
  output logic           stip,
  output logic           mtip,
  output logic           ueip,
  output logic           seip,
  output logic           meip
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0]    pcnt;
  logic [63:0]    mtime;
  logic [63:0]    mtimecmp;
  logic [2:0]     swi;                  // [0]=msip [1]=ssip [2]=usip
  logic [2:0]     sync_q [SYNC_STAGES];
  logic [2:0]     eip;
  logic           tick;
  logic           acc;
  logic           bad;
  logic           wr;
  logic           sel_swi;
  logic           sel_cmp_lo;
  logic           sel_cmp_hi;
  logic           sel_mt_lo;
  logic           sel_mt_hi;
  logic [RSZ-1:0] rd_val;

  always_comb begin
    sel_swi    = (addr[4:2] == 3'd0);
    sel_cmp_lo = (addr[4:2] == 3'd2);
    sel_cmp_hi = (addr[4:2] == 3'd3);
    sel_mt_lo  = (addr[4:2] == 3'd4);
    sel_mt_hi  = (addr[4:2] == 3'd5);
    bad        = (addr[1:0] != 2'b00) ||
                 !(sel_swi || sel_cmp_lo || sel_cmp_hi || sel_mt_lo || sel_mt_hi);
    // A request arriving while the previous ack is still high is ignored.
    acc        = req && !ack;
    wr         = acc && we && !bad;
    tick       = (pcnt == PS_LAST);
    rd_val     = '0;
    if (sel_swi)         rd_val[2:0] = swi;
    else if (sel_cmp_lo) rd_val      = mtimecmp[31:0];
    else if (sel_cmp_hi) rd_val      = mtimecmp[63:32];
    else if (sel_mt_lo)  rd_val      = mtime[31:0];
    else if (sel_mt_hi)  rd_val      = mtime[63:32];
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      pcnt     <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      swi      <= '0;
      mtip     <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
    end else begin
      // Prescaler free-runs; bus writes to mtime never restart it.
      pcnt <= tick ? '0 : pcnt + 16'd1;

      // A bus write to either mtime half wins over the tick and suppresses
      // the increment of the whole 64-bit value for that edge.
      if (wr && sel_mt_lo)      mtime[31:0]  <= wdata;
      else if (wr && sel_mt_hi) mtime[63:32] <= wdata;
      else if (tick)            mtime        <= mtime + 64'd1;

      if (wr && sel_cmp_lo) mtimecmp[31:0]  <= wdata;
      if (wr && sel_cmp_hi) mtimecmp[63:32] <= wdata;
      if (wr && sel_swi)    swi             <= wdata[2:0];

      mtip  <= (mtime >= mtimecmp);

      ack   <= acc;
      err   <= acc && bad;
      rdata <= (acc && !we && !bad) ? rd_val : '0;
    end
  end

  // External IRQs: SYNC_STAGES synchronizer flops followed by one output register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      eip <= '0;
    end else begin
      sync_q[0] <= ext_irq_async;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      eip <= sync_q[SYNC_STAGES-1];
    end
  end

  assign usip = swi[2];
  assign ssip = swi[1];
  assign msip = swi[0];
  assign utip = 1'b0;
  assign stip = 1'b0;
  assign ueip = eip[0];
  assign seip = eip[1];
  assign meip = eip[2];

endmodule

// File: doc/irq_pend_gen.md
Name: irq_pend_gen

Overview:
- Machine-level interrupt source block: 64-bit mtime/mtimecmp timer, software-interrupt register, external-interrupt synchronizers.
- Produces the registered pending bits that load mcsr.mip, upstream of the mode/interrupt-decision logic.
- Memory-mapped over a single-beat 32-bit req/ack bus from the data-memory path.

Parameters:
- PRESCALE, 1, clk_in cycles per mtime increment (1..65535).
- SYNC_STAGES, 2, flip-flop stages on each external IRQ input (>=2).
- RSZ, 32, bus data width (fixed 32).

Ports:
- clk_in  input  1  single clock.
- reset_in  input  1  asynchronous, active-low reset.
- req  input  1  bus request, sampled on posedge.
- we  input  1  1=write, 0=read; valid with req.
- addr  input  5  byte offset within block.
- wdata  input  32  write data.
- ack  output  1  one-cycle completion pulse.
- rdata  output  32  read data, valid with ack.
- err  output  1  bad access flag, valid with ack.
- ext_irq_async  input  3  [0]=user, [1]=supervisor, [2]=machine external IRQ; asynchronous, level.
- usip, ssip, msip  output  1 each  software pending bits.
- utip, stip, mtip  output  1 each  timer pending bits; utip/stip are tied 0.
- ueip, seip, meip  output  1 each  synchronized external pending bits.

Behaviour:
- Register map (word offsets):
  - 0x00 SWI: bit0=msip, bit1=ssip, bit2=usip; other bits read 0, writes ignored.
  - 0x08 MTIMECMP[31:0]
  - 0x0C MTIMECMP[63:32]
  - 0x10 MTIME[31:0]
  - 0x14 MTIME[63:32]
- Reset (reset_in=0, async): mtime=0, mtimecmp=all ones, SWI=0, prescale count=0, sync chains=0, all pending outputs=0, ack=0, err=0, rdata=0.
- Handshake:
  - req accepted in cycle N only when ack=0.
  - ack=1 in cycle N+1 for exactly one cycle; rdata/err valid that cycle.
  - req while ack=1 is ignored, so a held req gives one transaction every 2 cycles.
  - Writes take effect at the N+1 edge.
  - rdata=0 on writes and on errors.
- err=1, no state change, for:
  - addr[1:0]!=0;
  - addr not in the map (0x04, 0x18-0x1F).
- Prescaler:
  - Counter runs 0..PRESCALE-1.
  - Terminal count produces a tick; mtime += 1 at that edge.
  - mtime is 64-bit and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - Carry from the low word to the high word happens in the same cycle.
- Write to MTIME lo/hi on a tick edge: the written half takes wdata; the increment is suppressed for the whole 64-bit value that cycle; prescale count is not reset.
- Writes to MTIMECMP halves take effect immediately; no atomic pairing.
- mtip:
  - Registered: mtip <= (mtime >= mtimecmp), unsigned 64-bit compare.
  - Reflects mtime/mtimecmp one cycle late.
  - Cleared only by raising mtimecmp or lowering mtime.
- SWI bits are set/cleared by bus writes only.
- External IRQs: each bit passes SYNC_STAGES flops, then one output register. Latency = SYNC_STAGES+1 edges; level follows the input, no latching.
- Reset asserted mid-transaction: the pending ack is dropped; no ack is issued after reset release.

Test Plan:
- Reset: assert reset_in=0 mid-count, release -> mtime=0, read 0x08=0xFFFFFFFF, read 0x0C=0xFFFFFFFF, all pending outputs 0, ack=0.
- Timer, PRESCALE=4: run 40 cycles from reset -> read 0x10 = 10 (+/-1 for read latency). Write 0x08=20, 0x0C=0 -> mtip rises exactly 1 cycle after mtime becomes 20. Write 0x08=0xFFFFFFFF -> mtip falls 1 cycle later.
- Wrap: write 0x14=0xFFFFFFFF, 0x10=0xFFFFFFFE, PRESCALE=1 -> after 2 ticks mtime=0, high word 0; mtip follows the compare against mtimecmp.
- Write/tick collision: write 0x10=0x100 on a tick edge -> read returns 0x100 (not 0x101); next tick gives 0x101.
- Errors and handshake: read 0x04 -> ack with err=1, rdata=0. Read 0x11 -> err=1. Hold req high 6 cycles -> exactly 3 acks.
- External IRQ, SYNC_STAGES=2: pulse ext_irq_async[2] high for 5 cycles -> meip high 3 edges later, stays 5 cycles; ext_irq_async[1] -> seip; write 0x00=0x5 -> msip=1, usip=1, ssip=0 next cycle.
